// File: rtl/jzjpcc_fetch.sv
`default_nettype none
// jzjpcc_fetch: fetch stage and IF/ID register. Owns the PC, drives a synchronous
// instruction memory, and registers {instruction, pc, pc+4, valid, illegal} into decode.
module jzjpcc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_fetch,
  input  logic        redirect_execute,
  input  logic [31:0] redirectTarget_execute,
  output logic [29:0] instructionAddress_fetch,
  input  logic [31:0] instructionData_fetch,
  output logic [29:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic [31:0] pcPlus4_decode,
  output logic        valid_decode,
  output logic        illegalLength_decode
);

  localparam logic [31:0] PC_RESET = RESET_VECTOR - 32'd4;

  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [29:0] instr_q, instr_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic [31:0] pc4_dec_q, pc4_dec_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^redirectTarget_execute[1:0];

  always_comb begin
    pc_fetch_d    = pc_fetch_q + 32'd4;
    fetch_valid_d = fetch_valid_q;
    instr_d       = instr_q;
    pc_dec_d      = pc_dec_q;
    pc4_dec_d     = pc4_dec_q;
    valid_d       = valid_q;
    illegal_d     = illegal_q;

    if (redirect_execute) begin
      pc_fetch_d = {redirectTarget_execute[31:2], 2'b00};
    end else if (stall_fetch) begin
      pc_fetch_d = pc_fetch_q;
    end

    // A stalled fill keeps fetchValid low so the first imem read still matches pc_fetch.
    if (redirect_execute || !stall_fetch) begin
      fetch_valid_d = 1'b1;
    end

    if (redirect_execute || (!stall_fetch && !fetch_valid_q)) begin
      instr_d   = NOP_INSTR[31:2];
      pc_dec_d  = 32'd0;
      pc4_dec_d = 32'd4;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall_fetch) begin
      instr_d   = instructionData_fetch[31:2];
      pc_dec_d  = pc_fetch_q;
      pc4_dec_d = pc_fetch_q + 32'd4;
      valid_d   = 1'b1;
      illegal_d = (instructionData_fetch[1:0] != 2'b11);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_fetch_q    <= PC_RESET;
      fetch_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR[31:2];
      pc_dec_q      <= 32'd0;
      pc4_dec_q     <= 32'd4;
      valid_q       <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      pc_fetch_q    <= pc_fetch_d;
      fetch_valid_q <= fetch_valid_d;
      instr_q       <= instr_d;
      pc_dec_q      <= pc_dec_d;
      pc4_dec_q     <= pc4_dec_d;
      valid_q       <= valid_d;
      illegal_q     <= illegal_d;
    end
  end

  // During reset the stall input must not disturb the first address presented.
  assign instructionAddress_fetch = reset_n ? pc_fetch_d[31:2] : RESET_VECTOR[31:2];
  assign instruction_decode       = instr_q;
  assign pc_decode                = pc_dec_q;
  assign pcPlus4_decode           = pc4_dec_q;
  assign valid_decode             = valid_q;
  assign illegalLength_decode     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_fetch.sv
`default_nettype none
// tb_jzjpcc_fetch: directed self-checking bench for the fetch stage with a modelled imem.
module tb_jzjpcc_fetch;

  logic        clock;
  logic        reset_n;
  logic        stall_fetch;
  logic        redirect_execute;
  logic [31:0] redirectTarget_execute;
  logic [29:0] instructionAddress_fetch;
  logic [31:0] instructionData_fetch;
  logic [29:0] instruction_decode;
  logic [31:0] pc_decode;
  logic [31:0] pcPlus4_decode;
  logic        valid_decode;
  logic        illegalLength_decode;

  int checks;
  int errors;

  localparam logic [29:0] NOP_HI = 30'h00000004;
  localparam logic [29:0] ILLEGAL_ADDR = 30'h00000002;

  jzjpcc_fetch #(
    .RESET_VECTOR(32'h00000100),
    .NOP_INSTR   (32'h00000013)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .stall_fetch             (stall_fetch),
    .redirect_execute        (redirect_execute),
    .redirectTarget_execute  (redirectTarget_execute),
    .instructionAddress_fetch(instructionAddress_fetch),
    .instructionData_fetch   (instructionData_fetch),
    .instruction_decode      (instruction_decode),
    .pc_decode               (pc_decode),
    .pcPlus4_decode          (pcPlus4_decode),
    .valid_decode            (valid_decode),
    .illegalLength_decode    (illegalLength_decode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous imem: word at address A is {A, 2'b11}, except one non-32-bit word.
  always @(posedge clock) begin
    if (instructionAddress_fetch == ILLEGAL_ADDR)
      instructionData_fetch <= 32'h00000001;
    else
      instructionData_fetch <= {instructionAddress_fetch, 2'b11};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_dec(input string tag, input logic [31:0] pc, input logic [29:0] instr);
    check({tag, "_pc"}, pc_decode, pc);
    check({tag, "_pc4"}, pcPlus4_decode, pc + 32'd4);
    check({tag, "_instr"}, {2'b00, instruction_decode}, {2'b00, instr});
    check({tag, "_valid"}, {31'd0, valid_decode}, 32'd1);
    check({tag, "_illegal"}, {31'd0, illegalLength_decode}, 32'd0);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'd0, valid_decode}, 32'd0);
    check({tag, "_instr"}, {2'b00, instruction_decode}, {2'b00, NOP_HI});
    check({tag, "_illegal"}, {31'd0, illegalLength_decode}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    instructionData_fetch  = 32'h0;
    reset_n                = 1'b0;
    stall_fetch            = 1'b0;
    redirect_execute       = 1'b0;
    redirectTarget_execute = 32'h0;
    #12;
    check("rst_addr", {2'b00, instructionAddress_fetch}, 32'h40);
    check_bubble("rst");
    check("rst_pc", pc_decode, 32'h0);
    check("rst_pc4", pcPlus4_decode, 32'h4);
    @(negedge clock);
    reset_n = 1'b1;

    // Fill and sequential fetch
    step();
    check_bubble("fill");
    check("fill_addr", {2'b00, instructionAddress_fetch}, 32'h41);
    step();
    check_dec("seq0", 32'h100, 30'h40);
    check("seq0_addr", {2'b00, instructionAddress_fetch}, 32'h42);
    step();
    check_dec("seq1", 32'h104, 30'h41);
    step();
    check_dec("seq2", 32'h108, 30'h42);

    // Stall three cycles
    stall_fetch = 1'b1;
    #1;
    check("stall_addr", {2'b00, instructionAddress_fetch}, 32'h43);
    for (int i = 0; i < 3; i++) begin
      step();
      check_dec("stall_hold", 32'h108, 30'h42);
      check("stall_addr_hold", {2'b00, instructionAddress_fetch}, 32'h43);
    end
    stall_fetch = 1'b0;
    #1;
    check("unstall_addr", {2'b00, instructionAddress_fetch}, 32'h44);
    step();
    check_dec("after_stall", 32'h10C, 30'h43);

    // Redirect while fetching 0x110
    redirect_execute       = 1'b1;
    redirectTarget_execute = 32'h00000203;
    #1;
    check("redir_addr", {2'b00, instructionAddress_fetch}, 32'h80);
    step();
    redirect_execute = 1'b0;
    check_bubble("redir_bub");
    step();
    check_dec("redir_tgt", 32'h200, 30'h80);

    // Redirect and stall together: redirect wins
    redirect_execute       = 1'b1;
    stall_fetch            = 1'b1;
    redirectTarget_execute = 32'h00000200;
    #1;
    check("rs_addr", {2'b00, instructionAddress_fetch}, 32'h80);
    step();
    redirect_execute = 1'b0;
    stall_fetch      = 1'b0;
    check_bubble("rs_bub");
    step();
    check_dec("rs_tgt", 32'h200, 30'h80);

    // PC wrap
    redirect_execute       = 1'b1;
    redirectTarget_execute = 32'hFFFFFFF8;
    step();
    redirect_execute = 1'b0;
    check_bubble("wrap_bub");
    step();
    check_dec("wrap0", 32'hFFFFFFF8, 30'h3FFFFFFE);
    step();
    check_dec("wrap1", 32'hFFFFFFFC, 30'h3FFFFFFF);
    check("wrap1_pc4", pcPlus4_decode, 32'h0);
    step();
    check_dec("wrap2", 32'h0, 30'h0);
    step();
    check_dec("wrap3", 32'h4, 30'h1);

    // Non-32-bit encoding at pc 0x8
    step();
    check("ill_pc", pc_decode, 32'h8);
    check("ill_valid", {31'd0, valid_decode}, 32'd1);
    check("ill_flag", {31'd0, illegalLength_decode}, 32'd1);
    check("ill_instr", {2'b00, instruction_decode}, 32'h0);

    // Asynchronous reset mid-stream, well away from any clock edge
    #1;
    reset_n = 1'b0;
    #1;
    check_bubble("arst");
    check("arst_pc", pc_decode, 32'h0);
    check("arst_pc4", pcPlus4_decode, 32'h4);
    check("arst_addr", {2'b00, instructionAddress_fetch}, 32'h40);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    step();
    check_dec("rerun", 32'h100, 30'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
